mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch requester (IF stage) and the data requester (M stage) of the 5-stage RV32 core. It sits between the fetch/load-store logic and the memory macro, arbitrates requests, sequences each access with a three-state FSM, and returns registered read data with a one-cycle ready pulse. The pipeline uses the ready pulses as its stall release.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending (≥1)
- TIMEOUT, 16, ACCESS cycles without mem_ready before abort (≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_ready  out  1  one-cycle pulse, access complete
- if_rdata  out  DATA_W  fetched word, valid with if_ready
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse, access complete
- d_rdata  out  DATA_W  load data, valid with d_ready
- err  out  1  one-cycle pulse with x_ready when the access timed out
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory done; read data valid the same cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE behaviour:
  - Requests are sampled only in IDLE.
  - If no requests are pending, stay in IDLE.
  - If one request is pending, grant it.
  - If both are pending, data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - On a grant, register owner, we, addr and wdata, then go to ACCESS. A fetch grant forces we = 0.
- ACCESS behaviour:
  - mem_req = 1; mem_we, mem_addr and mem_wdata come from the registered values.
  - On mem_ready, capture mem_rdata into the owner's rdata register (loads and fetches only) and go to RESP.
  - If to_cnt reaches TIMEOUT-1 without mem_ready, abort: the owner's rdata becomes 0, err_pending is set, and the FSM goes to RESP.
- RESP behaviour: the owner's x_ready = 1 for one cycle, err = err_pending, then go to IDLE.
- Stores leave d_rdata unchanged.
- starve_cnt:
  - +1 on each data grant made while if_req = 1, saturating at STARVE_MAX.
  - Cleared on a fetch grant.
  - Cleared on a data grant while if_req = 0.
- to_cnt: cleared on entry to ACCESS, +1 per ACCESS cycle. Width is clog2(TIMEOUT).
- A requester that sees x_ready in cycle t and still holds req in cycle t+1 is making a new request.
- mem_ready outside ACCESS is ignored. This includes a late response after a timeout.
- Requests arriving during ACCESS or RESP wait. Address or data changes on a held request are not permitted.

## Timing
- All outputs are registered.
- Reset values: every output 0; state IDLE; starve_cnt, to_cnt and err_pending all 0.
- Latency with a zero-wait memory (mem_ready in the first ACCESS cycle):
  - Request high in cycle 0.
  - mem_req in cycle 1.
  - x_ready in cycle 2.
- With w wait cycles, x_ready arrives in cycle 2+w.
- Back-to-back throughput is one access per 3 cycles.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then RESP follows with err = 1.
- Reset asserted mid-access drops mem_req and every other output immediately (asynchronously). No response is ever delivered for the killed access.
- if_ready and d_ready are never high in the same cycle.

## Structure
- Shared package riscv_mem_pkg holds:
  - the arb_state_t enum (IDLE/ACCESS/RESP);
  - the owner_t enum (OWN_IF/OWN_D);
  - the ADDR_W and DATA_W defaults.
- Single module, no sub-modules. The FSM, the two counters and the capture registers are all inline.

## Test plan
- Fetch only, zero-wait memory: if_addr = 0x100 and mem_rdata = 0x00500093 → mem_addr = 0x100 in cycle 1; if_ready = 1 and if_rdata = 0x00500093 in cycle 2.
- Simultaneous if_req and d_req (load from 0x2000 returning 0xDEADBEEF) → data is served first (d_rdata = 0xDEADBEEF); the fetch is granted in the following IDLE.
- Starvation: d_req held continuously plus if_req, STARVE_MAX = 4 → exactly 4 d_ready pulses, then if_ready; the counter then restarts.
- Store: d_we = 1, d_addr = 0x2004, d_wdata = 0x12345678, memory with 3 wait cycles → mem_we = 1 for 4 cycles; d_ready in cycle 5; d_rdata unchanged.
- Timeout: mem_ready never asserted, TIMEOUT = 16 → mem_req high for 16 cycles, then d_ready = err = 1 with d_rdata = 0. A late mem_ready is ignored.
- Reset deasserted-to-asserted (rst driven low) mid-ACCESS → mem_req = 0 immediately; no ready pulse; after release, a new request is served normally.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified-memory port arbiter.
// FSM states, access owner and bus width defaults.
package riscv_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and M stage requesters onto one memory port.
// IDLE -> ACCESS -> RESP per access; ready pulses release stalls.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam int TO_W = $clog2(TIMEOUT);

  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;

  logic grant_if;
  logic grant_d;
  logic starved;

  // Arbitration: data wins unless fetch has been passed over STARVE_MAX times
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    starved  = (starve_q == SC_MAX);
    if (state_q == IDLE) begin
      if (d_req && !(if_req && starved)) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  // Access sequencer, counters and response capture
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    to_d        = to_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d     = OWN_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (!if_req) begin
            starve_d = '0;
          end else if (!starved) begin
            starve_d = starve_q + SC_W'(1);
          end
        end
        if (grant_if) begin
          owner_d    = OWN_IF;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          starve_d   = '0;
        end
        if (grant_d || grant_if) begin
          mem_req_d = 1'b1;
          to_d      = '0;
          state_d   = ACCESS;
        end
      end

      ACCESS: begin
        to_d = to_q + TO_W'(1);
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (owner_q == OWN_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_ready_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else if (to_q == TO_LAST) begin
          // Abort: the late response, if any, lands outside ACCESS
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          if (owner_q == OWN_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = '0;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset kills any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      to_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      to_q        <= to_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Directed timing cases, then randomized dual-requester traffic.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_if[$];
  exp_t exp_d[$];

  int n_chk = 0;
  int n_fail = 0;
  int if_rdy_total = 0;
  int d_rdy_total = 0;
  int mreq_cyc = 0;
  int we_cyc = 0;

  logic [31:0] macro   [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];
  logic [31:0] ref_last_d = '0;

  int mem_mode = 0;
  int fixed_wait = 0;
  bit late_pulse = 1'b0;
  bit in_acc = 1'b0;
  int wait_left = 0;

  function automatic void check(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return macro.exists(a) ? macro[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Memory macro: wait states chosen per access, driven at negedge
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && mem_req && mem_mode != 2) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          wait_left = (mem_mode == 1) ? $urandom_range(0, 3) : fixed_wait;
        end
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_rd(mem_addr);
          if (mem_we) macro[mem_addr] = mem_wdata;
          in_acc = 1'b0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          wait_left--;
        end
      end else begin
        if (!mem_req) in_acc = 1'b0;
        mem_ready = late_pulse && !mem_req;
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: pops expectations when a ready pulse appears
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_req) mreq_cyc++;
        if (mem_req && mem_we) we_cyc++;
        if (mem_req) begin
          check("mem_bus_matches_owner",
                ((if_req && mem_addr == if_addr && !mem_we) ||
                 (d_req && mem_addr == d_addr && mem_we == d_we &&
                  (!d_we || mem_wdata == d_wdata))), 1);
        end
        if (if_ready && d_ready) check("both_ready", 1, 0);
        if (err && !if_ready && !d_ready) check("err_alone", 1, 0);
        if (if_ready) begin
          if_rdy_total++;
          if (exp_if.size() == 0) begin
            check("if_unexpected_ready", 1, 0);
          end else begin
            e = exp_if.pop_front();
            check("if_rdata", if_rdata, e.data);
            check("if_err", err, e.err);
          end
        end
        if (d_ready) begin
          d_rdy_total++;
          if (exp_d.size() == 0) begin
            check("d_unexpected_ready", 1, 0);
          end else begin
            e = exp_d.pop_front();
            check("d_rdata", d_rdata, e.data);
            check("d_err", err, e.err);
          end
        end
      end
    end
  end

  task automatic issue_if(input logic [31:0] a);
    exp_t e;
    e.data = ref_rd(a);
    e.err  = 1'b0;
    exp_if.push_back(e);
    if_addr = a;
    if_req  = 1'b1;
  endtask

  // to = 1 marks a load that the memory will never answer
  task automatic issue_d(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input bit to);
    exp_t e;
    e.err = 1'b0;
    if (to) begin
      ref_last_d = '0;
      e.err = 1'b1;
    end else if (we) begin
      ref_mem[a] = wd;
    end else begin
      ref_last_d = ref_rd(a);
    end
    e.data = ref_last_d;
    exp_d.push_back(e);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
  endtask

  task automatic wait_rdy(input bit is_if, output int at);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    at = -1;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      seen = is_if ? if_ready : d_ready;
    end
    if (seen) at = cyc;
    else check(is_if ? "if_ready_timeout" : "d_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (is_if) if_req = 1'b0;
    else d_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int t0, ad, ai, base, g1, g2, m0, w0, r0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_readies", {if_ready, d_ready, err}, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // zero-wait fetch
    macro[32'h100] = 32'h00500093;
    ref_mem[32'h100] = 32'h00500093;
    t0 = cyc;
    issue_if(32'h100);
    @(negedge clk);
    check("fetch_c0_mem_req", mem_req, 0);
    @(negedge clk);
    check("fetch_c1_mem_req", mem_req, 1);
    check("fetch_c1_mem_addr", mem_addr, 32'h100);
    wait_rdy(1, ai);
    check("fetch_latency", ai - t0, 2);

    // simultaneous requests: data first
    macro[32'h2000] = 32'hDEADBEEF;
    ref_mem[32'h2000] = 32'hDEADBEEF;
    t0 = cyc;
    issue_d(1'b0, 32'h2000, '0, 1'b0);
    issue_if(32'h104);
    fork
      wait_rdy(0, ad);
      wait_rdy(1, ai);
    join
    check("both_d_latency", ad - t0, 2);
    check("both_if_latency", ai - t0, 5);

    // starvation with data held continuously
    base = d_rdy_total;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int x;
          issue_d(1'b0, 32'h2000 + 32'(4 * i), '0, 1'b0);
          wait_rdy(0, x);
        end
      end
      begin
        int x;
        issue_if(32'h200);
        wait_rdy(1, x);
        g1 = d_rdy_total - base;
        base = d_rdy_total;
        issue_if(32'h204);
        wait_rdy(1, x);
        g2 = d_rdy_total - base;
      end
    join
    check("starve_first_run", g1, SMAX);
    check("starve_second_run", g2, SMAX);

    // store with three wait cycles
    fixed_wait = 3;
    w0 = we_cyc;
    t0 = cyc;
    issue_d(1'b1, 32'h2004, 32'h12345678, 1'b0);
    wait_rdy(0, ad);
    check("store_latency", ad - t0, 5);
    check("store_we_cycles", we_cyc - w0, 4);
    fixed_wait = 0;
    issue_d(1'b0, 32'h2004, '0, 1'b0);
    wait_rdy(0, ad);

    // timeout, then a late mem_ready
    mem_mode = 2;
    m0 = mreq_cyc;
    t0 = cyc;
    issue_d(1'b0, 32'h2008, '0, 1'b1);
    wait_rdy(0, ad);
    check("timeout_latency", ad - t0, TMO + 1);
    check("timeout_mem_req_cycles", mreq_cyc - m0, TMO);
    r0 = d_rdy_total + if_rdy_total;
    late_pulse = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    late_pulse = 1'b0;
    check("late_ready_ignored", d_rdy_total + if_rdy_total, r0);
    check("late_ready_no_access", mem_req, 0);
    mem_mode = 0;
    t0 = cyc;
    issue_d(1'b0, 32'h2004, '0, 1'b0);
    wait_rdy(0, ad);
    check("after_timeout_latency", ad - t0, 2);

    // reset in the middle of an access
    fixed_wait = 6;
    issue_d(1'b0, 32'h200C, '0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_readies", {if_ready, d_ready, err}, 0);
    check("midrst_d_rdata", d_rdata, 0);
    exp_d.delete();
    ref_last_d = '0;
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    r0 = d_rdy_total + if_rdy_total;
    repeat (8) @(negedge clk);
    check("midrst_no_response", d_rdy_total + if_rdy_total, r0);
    @(posedge clk);
    #1;
    fixed_wait = 0;
    t0 = cyc;
    issue_d(1'b0, 32'h2004, '0, 1'b0);
    wait_rdy(0, ad);
    check("after_rst_latency", ad - t0, 2);
    issue_if(32'h108);
    wait_rdy(1, ai);

    // randomized traffic from both requesters
    mem_mode = 1;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int g, b, x;
          g = $urandom_range(0, 3);
          repeat (g) @(posedge clk);
          if (g != 0) #1;
          b = d_rdy_total;
          issue_if(32'h1000 + 32'(4 * $urandom_range(0, 255)));
          wait_rdy(1, x);
          check("if_starve_bound", (d_rdy_total - b) <= SMAX + 1, 1);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          int g, x;
          logic we;
          g = $urandom_range(0, 3);
          repeat (g) @(posedge clk);
          if (g != 0) #1;
          we = 1'($urandom_range(0, 1));
          issue_d(we, 32'h2000 + 32'(4 * $urandom_range(0, 15)),
                  $urandom, 1'b0);
          wait_rdy(0, x);
        end
      end
    join

    repeat (4) @(posedge clk);
    check("if_queue_drained", exp_if.size(), 0);
    check("d_queue_drained", exp_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
